// File: rtl/ysyx_icache_fetch.sv
// ysyx_icache_fetch: fetch stage with N-way set-associative I-cache and word-serial refill; YSYX_ICACHE_PERF_EN adds hit/miss counters
module ysyx_icache_fetch #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_valid,
    output logic              pc_ready,
    input  logic [ADDR_W-1:0] pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              fault_o,
    input  logic              flush_i,
    output logic [ADDR_W-1:0] araddr_o,
    output logic              arvalid_o,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rvalid,
    input  logic              rerr
`ifdef YSYX_ICACHE_PERF_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);
    localparam int OFF_W = $clog2(LINE_WORDS) + 2;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int WAY_W = WAYS > 1 ? $clog2(WAYS) : 1;
    localparam int WRD_W = LINE_WORDS > 1 ? $clog2(LINE_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESP} state_t;
    state_t state, state_n;

    logic [DATA_W-1:0] data_mem [WAYS][SETS][LINE_WORDS];
    logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
    logic [SETS-1:0]   valid    [WAYS];
    logic [WAY_W-1:0]  rr       [SETS];
    logic [ADDR_W-1:0] req_pc;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [WRD_W-1:0]  word, cnt;
    logic [WAY_W-1:0]  victim, victim_c;
    logic [DATA_W-1:0] hit_data;
    logic              hit, beat, last, kill;

    assign idx        = req_pc[OFF_W +: IDX_W];
    assign tag        = req_pc[ADDR_W-1 -: TAG_W];
    assign word       = LINE_WORDS > 1 ? req_pc[2 +: WRD_W] : '0;
    assign beat       = state == REFILL && !arvalid_o && rvalid;
    assign last       = cnt == WRD_W'(LINE_WORDS - 1);
    assign araddr_o   = {req_pc[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} | (ADDR_W'(cnt) << 2);
    assign pc_ready   = state == IDLE;
    assign inst_valid = state == RESP;
    assign pc_o       = req_pc;

    // tag compare across all ways; victim is the lowest invalid way, else the set's round-robin pointer
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        victim_c = rr[idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[w][idx] && tag_mem[w][idx] == tag) begin
                hit      = 1'b1;
                hit_data = data_mem[w][idx][word];
            end
            if (!valid[w][idx]) victim_c = WAY_W'(w);
        end
    end

    // next state: one request in flight, refill ends on error or the last beat
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = pc_valid ? LOOKUP : IDLE;
            LOOKUP:  state_n = hit ? RESP : REFILL;
            REFILL:  state_n = beat && (rerr || last) ? RESP : REFILL;
            RESP:    state_n = inst_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) state <= rst ? IDLE : state_n;

    // request, response and bus-issue registers
    always_ff @(posedge clk) begin
        if (rst) begin
            req_pc    <= '0;
            inst_o    <= '0;
            fault_o   <= 1'b0;
            arvalid_o <= 1'b0;
            cnt       <= '0;
            victim    <= '0;
            kill      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pc_valid) req_pc <= pc;
                LOOKUP: begin
                    inst_o    <= hit_data;
                    cnt       <= '0;
                    victim    <= victim_c;
                    kill      <= 1'b0;
                    arvalid_o <= !hit;
                end
                REFILL: begin
                    if (arvalid_o && arready) arvalid_o <= 1'b0;
                    if (flush_i) kill <= 1'b1;
                    if (beat) begin
                        if (rerr) begin
                            inst_o  <= '0;
                            fault_o <= 1'b1;
                        end else begin
                            if (cnt == word) inst_o <= rdata;
                            if (!last) begin
                                cnt       <= cnt + 1'b1;
                                arvalid_o <= 1'b1;
                            end
                        end
                    end
                end
                RESP: if (inst_ready) fault_o <= 1'b0;
                default: ;
            endcase
        end
    end

    // valid bits and RR pointers; a flush on the final beat suppresses the install
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < WAYS; w++) valid[w] <= '0;
            for (int s = 0; s < SETS; s++) rr[s] <= '0;
        end else if (flush_i) begin
            for (int w = 0; w < WAYS; w++) valid[w] <= '0;
        end else if (beat && !rerr && last && !kill) begin
            valid[victim][idx] <= 1'b1;
            rr[idx]            <= WAYS > 1 ? rr[idx] + 1'b1 : '0;
        end
    end

    // line data and tag storage, written beat by beat into the victim way
    always_ff @(posedge clk) begin
        if (beat && !rerr) begin
            data_mem[victim][idx][cnt] <= rdata;
            if (last) tag_mem[victim][idx] <= tag;
        end
    end

`ifdef YSYX_ICACHE_PERF_EN
    // lookup hit/miss counters, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (state == LOOKUP) begin
            if (hit) hit_cnt_o <= hit_cnt_o + 32'd1;
            else miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ysyx_icache_fetch.sv
// tb_ysyx_icache_fetch: directed fetch sequences against a stalling word-serial bus responder
module tb_ysyx_icache_fetch;
    logic        clk = 1'b0, rst = 1'b1, pc_valid = 1'b0, inst_ready = 1'b0;
    logic        flush_i = 1'b0, arready = 1'b0, rvalid = 1'b0, rerr = 1'b0;
    logic [31:0] pc = '0, rdata = '0;
    logic        pc_ready, inst_valid, fault_o, arvalid_o;
    logic [31:0] inst_o, pc_o, araddr_o;
`ifdef YSYX_ICACHE_PERF_EN
    logic [31:0] hit_cnt_o, miss_cnt_o;
`endif
    int checks = 0, errors = 0;
    int ar_cnt = 0, ar_viol = 0, err_beat = -1, flush_beat = -1;
    logic [31:0] ar_log[$];

    ysyx_icache_fetch dut (
        .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc_ready(pc_ready), .pc(pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_o(inst_o), .pc_o(pc_o),
        .fault_o(fault_o), .flush_i(flush_i), .araddr_o(araddr_o), .arvalid_o(arvalid_o),
        .arready(arready), .rdata(rdata), .rvalid(rvalid), .rerr(rerr)
`ifdef YSYX_ICACHE_PERF_EN
        , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] bus_data(input logic [31:0] a);
        return (a[31:4] == 28'h8000000) ? 32'h11 * ({30'd0, a[3:2]} + 32'd1) : (a ^ 32'hA5A50000);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // bus responder: arready stalls one cycle in three, data returns the cycle after the address handshake
    logic        resp_pend = 1'b0, prev_av = 1'b0, prev_hs = 1'b0;
    logic [31:0] resp_a = '0, prev_a = '0;
    int          tick = 0;
    always @(negedge clk) begin
        rvalid  = 1'b0;
        rerr    = 1'b0;
        flush_i = 1'b0;
        rdata   = '0;
        if (resp_pend) begin
            rvalid    = 1'b1;
            rdata     = bus_data(resp_a);
            rerr      = int'(resp_a[3:2]) == err_beat;
            flush_i   = int'(resp_a[3:2]) == flush_beat;
            resp_pend = 1'b0;
        end
        if (arvalid_o && prev_av && !prev_hs && araddr_o !== prev_a) ar_viol++;
        tick++;
        arready = (tick % 3) != 1;
        prev_av = arvalid_o;
        prev_a  = araddr_o;
        prev_hs = arvalid_o && arready;
        if (arvalid_o && arready) begin
            ar_cnt++;
            ar_log.push_back(araddr_o);
            resp_pend = 1'b1;
            resp_a    = araddr_o;
        end
    end

    task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp_inst,
                         input logic exp_fault, input int exp_ar, input int hold);
        int n0, cyc;
        @(negedge clk);
        check({tag, "/pc_ready"}, pc_ready, 1);
        pc       = a;
        pc_valid = 1'b1;
        n0       = ar_cnt;
        @(posedge clk);
        #1 pc_valid = 1'b0;
        cyc = 0;
        while (!inst_valid && cyc < 200) begin
            @(posedge clk);
            #1 cyc++;
        end
        if (!inst_valid) begin
            check({tag, "/timeout"}, inst_valid, 1);
            return;
        end
        if (exp_ar == 0) check({tag, "/hit_latency"}, cyc + 1, 2);
        check({tag, "/inst"}, inst_o, exp_inst);
        check({tag, "/pc_o"}, pc_o, a);
        check({tag, "/fault"}, fault_o, exp_fault);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1 check({tag, "/hold"}, {inst_o, pc_o, pc_ready, inst_valid}, {exp_inst, a, 2'b01});
        end
        @(negedge clk);
        check({tag, "/ar_count"}, ar_cnt - n0, exp_ar);
        inst_ready = 1'b1;
        @(posedge clk);
        #1 inst_ready = 1'b0;
        check({tag, "/done"}, {pc_ready, inst_valid, fault_o}, 3'b100);
    endtask

    initial begin
        int n0, cyc;
        repeat (3) @(posedge clk);
        #1 check("reset", {pc_ready, inst_valid, fault_o, arvalid_o, inst_o, pc_o}, {4'b1000, 64'd0});
        @(negedge clk) rst = 1'b0;

        ar_log.delete();
        fetch("cold_miss", 32'h80000008, 32'h33, 1'b0, 4, 0);
        check("cold_ar_n", ar_log.size(), 4);
        if (ar_log.size() >= 4)
            for (int k = 0; k < 4; k++) check("cold_ar_addr", ar_log[k], 32'h80000000 + 32'(4 * k));

        fetch("hit", 32'h8000000C, 32'h44, 1'b0, 0, 0);

        fetch("conf_b", 32'h80000400, bus_data(32'h80000400), 1'b0, 4, 0);
        fetch("conf_c", 32'h80000800, bus_data(32'h80000800), 1'b0, 4, 0);
        fetch("conf_b_hit", 32'h80000400, bus_data(32'h80000400), 1'b0, 0, 0);
        fetch("conf_a_miss", 32'h80000000, 32'h11, 1'b0, 4, 0);

        fetch("backpressure", 32'h80000004, 32'h22, 1'b0, 0, 5);

        err_beat = 1;
        fetch("rerr", 32'h80001014, 32'h0, 1'b1, 2, 0);
        err_beat = -1;
        fetch("rerr_refetch", 32'h80001014, bus_data(32'h80001014), 1'b0, 4, 0);

        flush_beat = 2;
        fetch("flush_mid", 32'h80002024, bus_data(32'h80002024), 1'b0, 4, 0);
        flush_beat = -1;
        fetch("flush_mid_re", 32'h80002024, bus_data(32'h80002024), 1'b0, 4, 0);
        fetch("flushed_old", 32'h80001014, bus_data(32'h80001014), 1'b0, 4, 0);

        flush_beat = 3;
        fetch("flush_last", 32'h8000303C, bus_data(32'h8000303C), 1'b0, 4, 0);
        flush_beat = -1;
        fetch("flush_last_re", 32'h8000303C, bus_data(32'h8000303C), 1'b0, 4, 0);
        fetch("installed_hit", 32'h80003038, bus_data(32'h80003038), 1'b0, 0, 0);

        @(negedge clk);
        pc       = 32'h80004000;
        pc_valid = 1'b1;
        n0       = ar_cnt;
        @(negedge clk) pc_valid = 1'b0;
        cyc = 0;
        while (ar_cnt == n0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_refill_issued", ar_cnt > n0, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 check("rst_refill", {arvalid_o, pc_ready, inst_valid, fault_o}, 4'b0100);
`ifdef YSYX_ICACHE_PERF_EN
        check("perf_reset", {hit_cnt_o, miss_cnt_o}, 64'd0);
`endif
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        fetch("post_rst_miss", 32'h8000303C, bus_data(32'h8000303C), 1'b0, 4, 0);
        fetch("post_rst_hit", 32'h80003038, bus_data(32'h80003038), 1'b0, 0, 0);
`ifdef YSYX_ICACHE_PERF_EN
        check("perf_counts", {hit_cnt_o, miss_cnt_o}, {32'd1, 32'd1});
`endif
        check("ar_stable", ar_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
